// File: rtl/pq_buffer_ctrl.sv
// Sequencer for the ping-pong buffer: bank swap on tick, full clear on init,
// and a valid/ready scan of the retired bank that zeroes each word behind the read.
module pq_buffer_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init_i,
    input  logic                  tick_i,
    input  logic                  acc_busy_i,
    input  logic                  acc_wr_en_i,
    input  logic [ADDR_WIDTH-1:0] acc_wr_addr_i,
    input  logic [DATA_WIDTH-1:0] acc_din_i,
    output logic                  acc_ready_o,
    output logic                  buf_ctrl_o,
    output logic                  buf_clear_o,
    output logic                  buf_wr_en1_o,
    output logic [ADDR_WIDTH-1:0] buf_wr_addr1_o,
    output logic [DATA_WIDTH-1:0] buf_din1_o,
    output logic                  buf_rd_en2_o,
    output logic [ADDR_WIDTH-1:0] buf_rd_addr2_o,
    output logic                  buf_wr_en2_o,
    output logic [ADDR_WIDTH-1:0] buf_wr_addr2_o,
    output logic [DATA_WIDTH-1:0] buf_din2_o,
    input  logic [DATA_WIDTH-1:0] buf_dout2_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [ADDR_WIDTH-1:0] out_addr_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  scan_done_o,
    output logic                  overrun_o
);
    localparam int DEPTH = 2**ADDR_WIDTH;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_CLEAR     = 2'd1;
    localparam logic [1:0] S_RUN       = 2'd2;
    localparam logic [1:0] S_SWAP_WAIT = 2'd3;

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_clr_cnt;
    logic [ADDR_WIDTH:0]   r_scan_cnt;
    logic                  r_scan_active;
    logic                  r_inflight;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic                  r_out_valid;
    logic [ADDR_WIDTH-1:0] r_out_addr;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_scan_done;
    logic                  r_overrun;
    logic                  r_buf_ctrl;

    logic w_run;
    logic w_clear;
    logic w_issue;
    logic w_accept;
    logic w_accept_last;
    logic w_swap;

    assign w_run   = (r_state == S_RUN);
    assign w_clear = (r_state == S_CLEAR);

    // One read at a time, and only when the output register is free or draining now.
    assign w_issue = r_scan_active && (r_scan_cnt < (ADDR_WIDTH+1)'(DEPTH)) && !r_inflight
                     && (!r_out_valid || out_ready_i);
    assign w_accept      = r_out_valid && out_ready_i;
    assign w_accept_last = w_accept && (r_out_addr == ADDR_WIDTH'(DEPTH-1));
    assign w_swap        = (r_state == S_SWAP_WAIT) && !acc_busy_i && !r_scan_active && !r_inflight;

    assign acc_ready_o    = w_run;
    assign buf_ctrl_o     = r_buf_ctrl;
    assign buf_clear_o    = w_clear;
    assign buf_wr_en1_o   = acc_wr_en_i && w_run;
    assign buf_wr_addr1_o = w_clear ? r_clr_cnt : (w_run ? acc_wr_addr_i : '0);
    assign buf_din1_o     = w_run ? acc_din_i : '0;
    assign buf_rd_en2_o   = w_issue;
    assign buf_rd_addr2_o = w_issue ? r_scan_cnt[ADDR_WIDTH-1:0] : '0;
    assign buf_wr_en2_o   = r_inflight;
    assign buf_wr_addr2_o = r_inflight ? r_rd_addr : '0;
    assign buf_din2_o     = '0;
    assign out_valid_o    = r_out_valid;
    assign out_addr_o     = r_out_addr;
    assign out_data_o     = r_out_data;
    assign scan_done_o    = r_scan_done;
    assign overrun_o      = r_overrun;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_clr_cnt  <= '0;
            r_overrun  <= 1'b0;
            r_buf_ctrl <= 1'b0;
        end else if (init_i) begin
            r_state   <= S_CLEAR;
            r_clr_cnt <= '0;
            r_overrun <= 1'b0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + 1'b1;
                    if (r_clr_cnt == ADDR_WIDTH'(DEPTH-1)) r_state <= S_RUN;
                end
                S_RUN: begin
                    if (tick_i) r_state <= S_SWAP_WAIT;
                end
                S_SWAP_WAIT: begin
                    // Being in SWAP_WAIT is the one pending tick; any further tick is lost.
                    if (tick_i) r_overrun <= 1'b1;
                    if (w_swap) begin
                        r_buf_ctrl <= ~r_buf_ctrl;
                        r_state    <= S_RUN;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_active <= 1'b0;
            r_scan_cnt    <= '0;
            r_inflight    <= 1'b0;
            r_rd_addr     <= '0;
            r_out_valid   <= 1'b0;
            r_out_addr    <= '0;
            r_out_data    <= '0;
            r_scan_done   <= 1'b0;
        end else begin
            r_scan_done <= w_accept_last;
            if (init_i) begin
                r_scan_active <= 1'b0;
                r_inflight    <= 1'b0;
                r_out_valid   <= 1'b0;
            end else begin
                if (w_swap) begin
                    r_scan_active <= 1'b1;
                    r_scan_cnt    <= '0;
                end else if (w_accept_last) begin
                    r_scan_active <= 1'b0;
                end
                if (w_issue) begin
                    r_scan_cnt <= r_scan_cnt + 1'b1;
                    r_rd_addr  <= r_scan_cnt[ADDR_WIDTH-1:0];
                end
                r_inflight <= w_issue;
                if (r_inflight) begin
                    r_out_valid <= 1'b1;
                    r_out_addr  <= r_rd_addr;
                    r_out_data  <= buf_dout2_i;
                end else if (w_accept) begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_pq_buffer_ctrl.sv
// Self-checking bench for pq_buffer_ctrl: cycle model of the sequencer plus a
// two-bank buffer stand-in, with directed scenarios and literal expectations.
module tb_pq_buffer_ctrl;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          init_i = 1'b0, tick_i = 1'b0, acc_busy_i = 1'b0, acc_wr_en_i = 1'b0;
    logic [AW-1:0] acc_wr_addr_i = '0;
    logic [DW-1:0] acc_din_i = '0;
    logic          acc_ready_o, buf_ctrl_o, buf_clear_o, buf_wr_en1_o;
    logic [AW-1:0] buf_wr_addr1_o, buf_rd_addr2_o, buf_wr_addr2_o, out_addr_o;
    logic [DW-1:0] buf_din1_o, buf_din2_o, out_data_o;
    logic          buf_rd_en2_o, buf_wr_en2_o, out_valid_o, scan_done_o, overrun_o;
    logic [DW-1:0] buf_dout2_i = '0;
    logic          out_ready_i = 1'b0;

    always #5 clk = ~clk;

    pq_buffer_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .init_i(init_i), .tick_i(tick_i),
        .acc_busy_i(acc_busy_i), .acc_wr_en_i(acc_wr_en_i),
        .acc_wr_addr_i(acc_wr_addr_i), .acc_din_i(acc_din_i),
        .acc_ready_o(acc_ready_o), .buf_ctrl_o(buf_ctrl_o), .buf_clear_o(buf_clear_o),
        .buf_wr_en1_o(buf_wr_en1_o), .buf_wr_addr1_o(buf_wr_addr1_o), .buf_din1_o(buf_din1_o),
        .buf_rd_en2_o(buf_rd_en2_o), .buf_rd_addr2_o(buf_rd_addr2_o),
        .buf_wr_en2_o(buf_wr_en2_o), .buf_wr_addr2_o(buf_wr_addr2_o), .buf_din2_o(buf_din2_o),
        .buf_dout2_i(buf_dout2_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_addr_o(out_addr_o), .out_data_o(out_data_o),
        .scan_done_o(scan_done_o), .overrun_o(overrun_o)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [AW-1:0] ix(input int v);
        return v[AW-1:0];
    endfunction

    always @(posedge clk) cyc++;

    // Buffer stand-in driven by the DUT, and the bench's own view of bank contents.
    logic [DW-1:0] bm    [2][DEPTH];
    logic [DW-1:0] m_mem [2][DEPTH];

    // Model: mode 0 idle, 1 clearing, 2 accepting writes, 3 waiting to swap.
    int            m_mode, m_clr, m_next, m_fetch, m_hold;
    bit            m_bank, m_scanning, m_ovr, m_done;
    logic [DW-1:0] m_fetch_data, m_hold_data, f_data;
    bit            e_issue, e_accept, e_swap, rb, prev_ctrl;

    int            clr_cycles, wr1_count, wr2_count, rd2_count, done_count, rdy_low;
    int            t_tick, t_tog, t_done;
    logic [15:0]   clr_mask;
    logic [AW-1:0] q_addr[$];
    logic [DW-1:0] q_data[$];

    task automatic model_reset;
        m_mode = 0; m_clr = 0; m_next = DEPTH; m_fetch = -1; m_hold = -1;
        m_bank = 1'b0; m_scanning = 1'b0; m_ovr = 1'b0; m_done = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            model_reset();
            chk("rst_acc_ready", 32'(acc_ready_o), 0);
            chk("rst_buf_ctrl", 32'(buf_ctrl_o), 0);
            chk("rst_clear", 32'(buf_clear_o), 0);
            chk("rst_out_valid", 32'(out_valid_o), 0);
            chk("rst_rd_en2", 32'(buf_rd_en2_o), 0);
            chk("rst_wr_en2", 32'(buf_wr_en2_o), 0);
            chk("rst_overrun", 32'(overrun_o), 0);
            chk("rst_scan_done", 32'(scan_done_o), 0);
        end else begin
            rb       = !m_bank;
            e_issue  = m_scanning && m_next < DEPTH && m_fetch < 0 && (m_hold < 0 || out_ready_i);
            e_accept = m_hold >= 0 && out_ready_i;
            e_swap   = m_mode == 3 && !acc_busy_i && !m_scanning && m_fetch < 0;

            chk("acc_ready", 32'(acc_ready_o), 32'(m_mode == 2));
            chk("buf_clear", 32'(buf_clear_o), 32'(m_mode == 1));
            chk("wr_en1", 32'(buf_wr_en1_o), 32'(m_mode == 2 && acc_wr_en_i));
            chk("wr_addr1", 32'(buf_wr_addr1_o),
                m_mode == 1 ? 32'(m_clr) : (m_mode == 2 ? 32'(acc_wr_addr_i) : 0));
            chk("din1", 32'(buf_din1_o), m_mode == 2 ? 32'(acc_din_i) : 0);
            chk("rd_en2", 32'(buf_rd_en2_o), 32'(e_issue));
            chk("rd_addr2", 32'(buf_rd_addr2_o), e_issue ? 32'(m_next) : 0);
            chk("wr_en2", 32'(buf_wr_en2_o), 32'(m_fetch >= 0));
            chk("wr_addr2", 32'(buf_wr_addr2_o), m_fetch >= 0 ? 32'(m_fetch) : 0);
            chk("din2", 32'(buf_din2_o), 0);
            chk("out_valid", 32'(out_valid_o), 32'(m_hold >= 0));
            if (m_hold >= 0) begin
                chk("out_addr", 32'(out_addr_o), 32'(m_hold));
                chk("out_data", 32'(out_data_o), 32'(m_hold_data));
            end
            chk("scan_done", 32'(scan_done_o), 32'(m_done));
            chk("overrun", 32'(overrun_o), 32'(m_ovr));
            chk("buf_ctrl", 32'(buf_ctrl_o), 32'(m_bank));

            if (buf_clear_o) begin
                clr_cycles++;
                if (buf_din1_o == '0) clr_mask[buf_wr_addr1_o] = 1'b1;
            end
            if (tick_i) t_tick = cyc;
            if (buf_ctrl_o != prev_ctrl) t_tog = cyc;
            if (!acc_ready_o) rdy_low++;
            if (out_valid_o && out_ready_i) begin
                q_addr.push_back(out_addr_o);
                q_data.push_back(out_data_o);
            end
            if (scan_done_o) begin done_count++; t_done = cyc; end
            if (buf_wr_en2_o && buf_din2_o == '0) wr2_count++;
            if (buf_wr_en1_o) wr1_count++;
            if (buf_rd_en2_o) rd2_count++;

            if (buf_clear_o) begin bm[0][buf_wr_addr1_o] = '0; bm[1][buf_wr_addr1_o] = '0; end
            if (buf_wr_en1_o) bm[buf_ctrl_o][buf_wr_addr1_o] = buf_din1_o;
            if (buf_rd_en2_o) buf_dout2_i = bm[!buf_ctrl_o][buf_rd_addr2_o];
            if (buf_wr_en2_o) bm[!buf_ctrl_o][buf_wr_addr2_o] = buf_din2_o;

            if (m_mode == 1) begin m_mem[0][ix(m_clr)] = '0; m_mem[1][ix(m_clr)] = '0; end
            if (m_mode == 2 && acc_wr_en_i) m_mem[m_bank][acc_wr_addr_i] = acc_din_i;
            f_data = e_issue ? m_mem[rb][ix(m_next)] : '0;
            if (m_fetch >= 0) m_mem[rb][ix(m_fetch)] = '0;
            m_done = e_accept && m_hold == DEPTH - 1;

            if (init_i) begin
                m_mode = 1; m_clr = 0; m_scanning = 1'b0; m_fetch = -1; m_hold = -1; m_ovr = 1'b0;
            end else begin
                if (m_mode == 1) begin
                    if (m_clr == DEPTH - 1) m_mode = 2;
                    m_clr = (m_clr + 1) % DEPTH;
                end else if (m_mode == 2) begin
                    if (tick_i) m_mode = 3;
                end else if (m_mode == 3) begin
                    if (tick_i) m_ovr = 1'b1;
                    if (e_swap) begin
                        m_bank = !m_bank; m_scanning = 1'b1; m_next = 0; m_mode = 2;
                    end
                end
                if (e_accept) begin
                    if (m_hold == DEPTH - 1) m_scanning = 1'b0;
                    m_hold = -1;
                end
                if (m_fetch >= 0) begin
                    m_hold = m_fetch; m_hold_data = m_fetch_data; m_fetch = -1;
                end
                if (e_issue) begin
                    m_fetch = m_next; m_fetch_data = f_data; m_next++;
                end
            end
        end
        prev_ctrl = buf_ctrl_o;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick;
        tick_i = 1'b1; step(1); tick_i = 1'b0;
    endtask

    task automatic pulse_init;
        init_i = 1'b1; step(1); init_i = 1'b0;
    endtask

    task automatic acc_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        acc_wr_en_i = 1'b1; acc_wr_addr_i = a; acc_din_i = d;
        step(1);
        acc_wr_en_i = 1'b0; acc_wr_addr_i = '0; acc_din_i = '0;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!acc_ready_o && n < 40) begin step(1); n++; end
        chk(name, 32'(acc_ready_o), 1);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        int start = done_count;
        while (done_count == start && n < 120) begin step(1); n++; end
        chk(name, 32'(done_count != start), 1);
    endtask

    task automatic wait_word(input string name, input int a);
        int n = 0;
        while (!(out_valid_o && out_addr_o == ix(a)) && n < 80) begin step(1); n++; end
        chk(name, 32'(out_valid_o && out_addr_o == ix(a)), 1);
    endtask

    task automatic clear_q;
        q_addr.delete();
        q_data.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] acc_or;
        int b;
        for (int i = 0; i < DEPTH; i++) begin
            bm[0][i] = 8'hEE; bm[1][i] = 8'hEE; m_mem[0][i] = 8'hEE; m_mem[1][i] = 8'hEE;
        end
        step(3);
        chk("lit_rst_ctrl", 32'(buf_ctrl_o), 0);
        chk("lit_rst_ready", 32'(acc_ready_o), 0);
        rst_n = 1'b1;
        step(2);

        // Full clear: 16 cycles sweeping 0..15 with zero data.
        clr_cycles = 0; clr_mask = '0;
        pulse_init();
        wait_ready("clear_to_run");
        chk("lit_clear_cycles", 32'(clr_cycles), 16);
        chk("lit_clear_addrs", 32'(clr_mask), 32'h0000FFFF);

        // First swap and scan.
        acc_write(4'd3, 8'h5A);
        acc_write(4'd15, 8'h11);
        out_ready_i = 1'b1; rdy_low = 0; t_tog = -1; wr2_count = 0; done_count = 0;
        clear_q();
        pulse_tick();
        step(3);
        chk("lit_tick_to_toggle", 32'(t_tog - t_tick), 2);
        chk("lit_ready_low", 32'(rdy_low), 1);
        wait_done("scan1_done");
        step(4);
        chk("lit_scan1_words", 32'(q_addr.size()), 16);
        chk("lit_scan1_done_once", 32'(done_count), 1);
        chk("lit_scan1_zero_backs", 32'(wr2_count), 16);
        for (int i = 0; i < DEPTH && i < q_addr.size(); i++) begin
            chk("lit_scan1_addr", 32'(q_addr[i]), 32'(i));
            chk("lit_scan1_data", 32'(q_data[i]), i == 3 ? 32'h5A : (i == 15 ? 32'h11 : 0));
        end

        // Two further scans: the other bank, then the zeroed-back first bank.
        for (int s = 0; s < 2; s++) begin
            clear_q();
            pulse_tick();
            wait_done("rescan_done");
            step(2);
            acc_or = '0;
            foreach (q_data[i]) acc_or |= q_data[i];
            chk("lit_rescan_words", 32'(q_addr.size()), 16);
            chk("lit_rescan_zero", 32'(acc_or), 0);
        end

        // Stall with out_ready low for 10 cycles on word 5.
        acc_write(4'd5, 8'hC3);
        clear_q();
        pulse_tick();
        wait_word("stall_reach", 5);
        out_ready_i = 1'b0; rd2_count = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("lit_stall_valid", 32'(out_valid_o), 1);
            chk("lit_stall_addr", 32'(out_addr_o), 5);
            chk("lit_stall_data", 32'(out_data_o), 32'hC3);
        end
        chk("lit_stall_no_reads", 32'(rd2_count), 0);
        out_ready_i = 1'b1;
        wait_done("stall_scan_done");
        step(2);
        chk("lit_stall_words", 32'(q_addr.size()), 16);

        // Pending tick during scan, then a dropped tick.
        pulse_tick();
        wait_word("ovr_reach", 2);
        t_tog = -1;
        pulse_tick();
        step(2);
        pulse_tick();
        step(1);
        chk("lit_overrun_set", 32'(overrun_o), 1);
        chk("lit_no_toggle_before_done", 32'(t_tog), 32'hFFFFFFFF);
        wait_done("ovr_scan_done");
        b = 0;
        while (t_tog < 0 && b < 10) begin step(1); b++; end
        chk("lit_toggle_after_done", 32'(t_tog > t_done && t_tog - t_done <= 2), 1);
        wait_done("ovr_scan2_done");
        step(2);
        chk("lit_overrun_sticky", 32'(overrun_o), 1);
        pulse_init();
        chk("lit_overrun_cleared", 32'(overrun_o), 0);
        wait_ready("reclear_to_run");

        // Accumulator busy holds off the swap; writes during the wait are dropped.
        chk("lit_ctrl_before_busy", 32'(buf_ctrl_o), 0);
        acc_busy_i = 1'b1; t_tog = -1; wr1_count = 0;
        pulse_tick();
        acc_wr_en_i = 1'b1; acc_wr_addr_i = 4'd7; acc_din_i = 8'h77;
        step(4);
        acc_wr_en_i = 1'b0; acc_wr_addr_i = '0; acc_din_i = '0;
        chk("lit_busy_no_toggle", 32'(t_tog), 32'hFFFFFFFF);
        chk("lit_busy_no_wr1", 32'(wr1_count), 0);
        acc_busy_i = 1'b0;
        b = cyc;
        step(3);
        chk("lit_busy_release_toggle", 32'(t_tog - b), 1);
        chk("lit_ctrl_after_busy", 32'(buf_ctrl_o), 1);

        // Asynchronous reset in the middle of that scan.
        wait_word("rst_reach", 4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("lit_async_rst_valid", 32'(out_valid_o), 0);
        chk("lit_async_rst_ctrl", 32'(buf_ctrl_o), 0);
        chk("lit_async_rst_ready", 32'(acc_ready_o), 0);
        step(2);
        rst_n = 1'b1;
        step(2);
        chk("lit_idle_after_rst", 32'(acc_ready_o), 0);
        pulse_init();
        wait_ready("post_rst_clear");
        clear_q();
        pulse_tick();
        wait_done("post_rst_scan_done");
        step(2);
        chk("lit_post_rst_words", 32'(q_addr.size()), 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
